// File: rtl/motor_profile_ctrl.sv
// Single-axis step/direction engine. Period words stream into a one-entry prefetch buffer
// and drive accel/cruise/decel or uniform step profiles, with hold, abort and underrun flagging.
module motor_profile_ctrl #(
    parameter int STEP_W  = 32,
    parameter int PER_W   = 32,
    parameter int PHASE_W = 16,
    parameter int POS_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    hold,
    input  logic [1:0]              pul_mode,
    input  logic [STEP_W-1:0]       step,
    input  logic [PHASE_W-1:0]      accel_end,
    input  logic [PHASE_W-1:0]      decel_begin,
    input  logic                    pul_dir,
    input  logic                    pos_clr,
    input  logic [PER_W-1:0]        per_data,
    input  logic                    per_valid,
    output logic                    per_ready,
    output logic                    pul_out,
    output logic                    dir_out,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun,
    output logic [STEP_W-1:0]       step_cnt,
    output logic signed [POS_W-1:0] step_pos,
    output logic [PER_W-1:0]        cur_period
);
    localparam int CW = ((STEP_W > PHASE_W) ? STEP_W : PHASE_W) + 1;

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_HOLD, S_STALL} state_t;
    state_t state, state_nx;

    logic [STEP_W-1:0]  n_lat, fetch_total, fetch_cnt, next_k;
    logic [PHASE_W-1:0] a_eff, d_lat, a_in;
    logic [PER_W-1:0]   buf_data, period_cnt;
    logic               uni_lat, buf_vld;
    logic               start_ok, at_end, last_step, fresh, decide, consume, to_stall, xfer;

    function automatic logic [PER_W-1:0] clamp_period(input logic [PER_W-1:0] w);
        return (w < PER_W'(2)) ? PER_W'(2) : w;
    endfunction

    function automatic logic needs_fresh(input logic uni, input logic [STEP_W-1:0] k,
                                         input logic [PHASE_W-1:0] a, input logic [PHASE_W-1:0] d);
        if (uni) return (k == '0);
        return (CW'(k) < CW'(a)) || (CW'(k) >= CW'(d));
    endfunction

    // Number of period words the whole motion will pull from the stream.
    function automatic logic [STEP_W-1:0] fetch_need(input logic uni, input logic [STEP_W-1:0] n,
                                                     input logic [PHASE_W-1:0] a, input logic [PHASE_W-1:0] d);
        logic [CW-1:0] nn, aa, dd, amin, dmin;
        nn   = CW'(n);
        aa   = CW'(a);
        dd   = CW'(d);
        amin = (aa < nn) ? aa : nn;
        dmin = (dd < nn) ? dd : nn;
        if (uni) return STEP_W'(1);
        if (aa >= dd) return n;
        return STEP_W'(amin + nn - dmin);
    endfunction

    assign a_in      = (accel_end == '0) ? PHASE_W'(1) : accel_end;
    assign start_ok  = start && (step != '0) && (pul_mode == 2'b01 || pul_mode == 2'b10);
    assign at_end    = (state == S_RUN) && (period_cnt == cur_period - PER_W'(1));
    assign last_step = (step_cnt + STEP_W'(1)) == n_lat;
    assign next_k    = (state == S_RUN) ? step_cnt + STEP_W'(1) : step_cnt;
    assign fresh     = needs_fresh(uni_lat, next_k, a_eff, d_lat);
    assign decide    = (at_end && !last_step && !hold) || (state == S_HOLD && !hold);
    assign to_stall  = decide && fresh && !buf_vld;
    assign consume   = buf_vld && (state == S_PRIME || state == S_STALL || (decide && fresh));
    assign xfer      = per_valid && per_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort && state != S_IDLE) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_ok) state_nx = S_PRIME;
                S_PRIME: if (buf_vld) state_nx = S_RUN;
                S_RUN: begin
                    if (at_end) begin
                        if (last_step)     state_nx = S_IDLE;
                        else if (hold)     state_nx = S_HOLD;
                        else if (to_stall) state_nx = S_STALL;
                        else               state_nx = S_RUN;
                    end
                end
                S_HOLD:  if (!hold) state_nx = to_stall ? S_STALL : S_RUN;
                S_STALL: if (buf_vld) state_nx = S_RUN;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        per_ready = (state != S_IDLE) && !buf_vld && (fetch_cnt < fetch_total);
        pul_out   = (state == S_RUN) && (period_cnt < (cur_period >> 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            underrun    <= 1'b0;
            dir_out     <= 1'b0;
            step_cnt    <= '0;
            step_pos    <= '0;
            cur_period  <= '0;
            period_cnt  <= '0;
            buf_vld     <= 1'b0;
            fetch_cnt   <= '0;
            fetch_total <= '0;
            n_lat       <= '0;
            uni_lat     <= 1'b0;
            a_eff       <= '0;
            d_lat       <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && start_ok) begin
                n_lat       <= step;
                uni_lat     <= (pul_mode == 2'b10);
                dir_out     <= pul_dir;
                a_eff       <= a_in;
                d_lat       <= decel_begin;
                fetch_total <= fetch_need(pul_mode == 2'b10, step, a_in, decel_begin);
                fetch_cnt   <= '0;
                step_cnt    <= '0;
                underrun    <= 1'b0;
                buf_vld     <= 1'b0;
            end else if (abort && state != S_IDLE) begin
                buf_vld <= 1'b0;
            end else begin
                if (xfer) begin
                    buf_vld   <= 1'b1;
                    buf_data  <= per_data;
                    fetch_cnt <= fetch_cnt + STEP_W'(1);
                end else if (consume) begin
                    buf_vld <= 1'b0;
                end
                if (consume) begin
                    cur_period <= clamp_period(buf_data);
                    period_cnt <= '0;
                end else if (state == S_RUN) begin
                    period_cnt <= at_end ? '0 : period_cnt + PER_W'(1);
                end
                if (at_end) begin
                    step_cnt <= step_cnt + STEP_W'(1);
                    done     <= last_step;
                end
                if (to_stall) underrun <= 1'b1;
            end
            // A clear request beats the position update of a completing step.
            if (pos_clr)
                step_pos <= '0;
            else if (at_end && !abort)
                step_pos <= dir_out ? step_pos + POS_W'(1) : step_pos - POS_W'(1);
        end
    end
endmodule

// File: tb/tb_motor_profile_ctrl.sv
// Bench for motor_profile_ctrl: hand-written vectors, directed corner sequences and random
// motions compared against a step-by-step profile model.
module tb_motor_profile_ctrl;
    localparam int STEP_W = 32, PER_W = 32, PHASE_W = 16, POS_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, abort = 1'b0, hold = 1'b0, pul_dir = 1'b0, pos_clr = 1'b0;
    logic [1:0] pul_mode = 2'b00;
    logic [STEP_W-1:0] step = '0;
    logic [PHASE_W-1:0] accel_end = '0, decel_begin = '0;
    logic [PER_W-1:0] per_data = '0;
    logic per_valid = 1'b0;
    logic per_ready, pul_out, dir_out, busy, done, underrun;
    logic [STEP_W-1:0] step_cnt;
    logic signed [POS_W-1:0] step_pos;
    logic [PER_W-1:0] cur_period;

    always #5 clk = ~clk;

    motor_profile_ctrl #(.STEP_W(STEP_W), .PER_W(PER_W), .PHASE_W(PHASE_W), .POS_W(POS_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold), .pul_mode(pul_mode),
        .step(step), .accel_end(accel_end), .decel_begin(decel_begin), .pul_dir(pul_dir),
        .pos_clr(pos_clr), .per_data(per_data), .per_valid(per_valid), .per_ready(per_ready),
        .pul_out(pul_out), .dir_out(dir_out), .busy(busy), .done(done), .underrun(underrun),
        .step_cnt(step_cnt), .step_pos(step_pos), .cur_period(cur_period));

    int n_tests = 0, n_fail = 0;
    int wlist[$], dlist[$], exp_per[$];
    int clr_gen = 0;
    logic signed [POS_W-1:0] exp_pos = '0;

    // Stream producer and pulse monitor, owned by one process; clr_gen requests a fresh start.
    int seen_gen = 0, pidx = 0, wait_ctr = 0, hs_cnt = 0, rdy_idle = 0, done_cnt = 0;
    int hi_q[$], lo_q[$];
    int hi_run = 0, lo_run = 0;
    bit in_low = 0, prev_pul = 0, hs = 0;

    always begin : bfm
        @(negedge clk);
        if (clr_gen != seen_gen) begin
            seen_gen = clr_gen; pidx = 0; wait_ctr = 0; hs_cnt = 0; rdy_idle = 0; done_cnt = 0;
            hi_q.delete(); lo_q.delete(); hi_run = 0; lo_run = 0; in_low = 0; prev_pul = 0;
        end
        hs = per_valid && per_ready;
        if (busy && per_ready && !per_valid) rdy_idle++;
        if (done) done_cnt++;
        if (pul_out) begin
            if (!prev_pul && in_low) begin lo_q.push_back(lo_run); in_low = 0; end
            hi_run++;
        end else begin
            if (prev_pul) begin hi_q.push_back(hi_run); hi_run = 0; lo_run = 0; in_low = 1; end
            if (in_low) begin
                if (busy) lo_run++;
                else begin lo_q.push_back(lo_run); in_low = 0; end
            end
        end
        prev_pul = pul_out;
        @(posedge clk); #1;
        if (hs) begin
            pidx++; hs_cnt++;
            wait_ctr = (pidx < dlist.size()) ? dlist[pidx] : 0;
        end else if (wait_ctr > 0) begin
            wait_ctr--;
        end
        per_valid = (pidx < wlist.size()) && (wait_ctr == 0);
        per_data  = (pidx < wlist.size()) ? PER_W'(wlist[pidx]) : '0;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int bound);
        n_tests++; n_fail++;
        $display("FAIL %s: timed out after %0d cycles", name, bound);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int c = 0;
        while (busy && c < bound) begin tick(1); c++; end
        if (busy) timeout_fail({name, " wait_idle"}, bound);
    endtask

    task automatic wait_steps(input string name, input int target, input int bound);
        int c = 0;
        while (step_cnt != STEP_W'(target) && c < bound) begin tick(1); c++; end
        if (step_cnt != STEP_W'(target)) timeout_fail({name, " wait_steps"}, bound);
    endtask

    task automatic wait_pulse(input string name, input int bound);
        int c = 0;
        while (!pul_out && c < bound) begin tick(1); c++; end
        if (!pul_out) timeout_fail({name, " wait_pulse"}, bound);
    endtask

    task automatic set_motion(input bit uni, input int n, input int a, input int d, input bit dir);
        clr_gen++;
        pul_mode = uni ? 2'b10 : 2'b01;
        step = STEP_W'(n); accel_end = PHASE_W'(a); decel_begin = PHASE_W'(d); pul_dir = dir;
        tick(2);
    endtask

    task automatic run_motion(input string name, input bit uni, input int n, input int a, input int d, input bit dir);
        set_motion(uni, n, a, d, dir);
        start = 1'b1; tick(1); start = 1'b0;
        wait_idle(name, n * 40 + 200);
        tick(1);
    endtask

    task automatic check_motion(input string name, input int n, input int f, input bit dir, input bit strict);
        int per;
        check({name, " fetches"}, hs_cnt, f);
        check({name, " pulses"}, hi_q.size(), n);
        for (int k = 0; k < n && k < hi_q.size(); k++) begin
            per = exp_per[k];
            check($sformatf("%s high[%0d]", name, k), hi_q[k], per / 2);
            if (strict && k < lo_q.size())
                check($sformatf("%s low[%0d]", name, k), lo_q[k], per - per / 2);
        end
        if (strict) begin
            check({name, " ready_extra"}, rdy_idle, 0);
            check({name, " underrun"}, underrun, 0);
        end
        check({name, " done_pulses"}, done_cnt, 1);
        check({name, " step_cnt"}, step_cnt, n);
        for (int k = 0; k < n; k++) exp_pos = dir ? exp_pos + 8'sd1 : exp_pos - 8'sd1;
        check({name, " step_pos"}, longint'(step_pos), longint'(exp_pos));
    endtask

    // Reference profile: walk the steps, pull a new (clamped) word when the rule asks for one.
    task automatic build_random(input bit uni, input int n, input int a, input int d);
        int ae, p, w;
        bit fresh;
        wlist.delete(); dlist.delete(); exp_per.delete();
        ae = (a < 1) ? 1 : a;
        p = 0;
        for (int k = 0; k < n; k++) begin
            fresh = uni ? (k == 0) : (k < ae || k >= d);
            if (fresh) begin
                w = $urandom_range(0, 12);
                wlist.push_back(w); dlist.push_back(0);
                p = (w < 2) ? 2 : w;
            end
            exp_per.push_back(p);
        end
    endtask

    typedef struct {
        bit uni; int n; int a; int d; bit dir; int nw; int w[6]; int f; int per[6];
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 3, 0, 0,  1'b1, 1, '{10, 0, 0, 0, 0, 0},   1, '{10, 10, 10, 0, 0, 0}};
        tbl[1] = '{1'b0, 6, 2, 4,  1'b1, 4, '{20, 10, 10, 20, 0, 0}, 4, '{20, 10, 10, 10, 10, 20}};
        tbl[2] = '{1'b0, 3, 0, 3,  1'b0, 1, '{1, 0, 0, 0, 0, 0},     1, '{2, 2, 2, 0, 0, 0}};
        tbl[3] = '{1'b0, 4, 3, 2,  1'b0, 4, '{6, 7, 8, 9, 0, 0},     4, '{6, 7, 8, 9, 0, 0}};
        tbl[4] = '{1'b1, 1, 0, 0,  1'b1, 1, '{0, 0, 0, 0, 0, 0},     1, '{2, 0, 0, 0, 0, 0}};
        tbl[5] = '{1'b0, 5, 5, 10, 1'b1, 5, '{4, 5, 6, 7, 8, 0},     5, '{4, 5, 6, 7, 8, 0}};

        // Reset state, with start and abort asserted to show reset wins.
        start = 1'b1; abort = 1'b1; pul_mode = 2'b10; step = 32'd3;
        tick(3);
        check("rst busy", busy, 0);
        check("rst per_ready", per_ready, 0);
        check("rst pul_out", pul_out, 0);
        check("rst done", done, 0);
        check("rst underrun", underrun, 0);
        check("rst dir_out", dir_out, 0);
        check("rst step_cnt", step_cnt, 0);
        check("rst step_pos", longint'(step_pos), 0);
        check("rst cur_period", cur_period, 0);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        tick(2);

        // Ignored starts.
        pul_mode = 2'b11; step = 32'd5; start = 1'b1; tick(1); start = 1'b0; tick(1);
        check("ign mode11 busy", busy, 0);
        check("ign mode11 per_ready", per_ready, 0);
        pul_mode = 2'b00; start = 1'b1; tick(1); start = 1'b0; tick(1);
        check("ign mode00 busy", busy, 0);
        pul_mode = 2'b01; step = 32'd0; start = 1'b1; tick(1); start = 1'b0; tick(1);
        check("ign step0 busy", busy, 0);
        check("ign step0 per_ready", per_ready, 0);

        // Start latency: PRIME next cycle, first pulse three cycles after start.
        wlist = '{10}; dlist = '{0}; exp_per = '{10, 10};
        set_motion(1'b1, 2, 0, 0, 1'b1);
        start = 1'b1; tick(1); start = 1'b0;
        check("lat busy t+1", busy, 1);
        check("lat per_ready t+1", per_ready, 1);
        tick(1);
        check("lat pul_out t+2", pul_out, 0);
        tick(1);
        check("lat pul_out t+3", pul_out, 1);
        check("lat cur_period t+3", cur_period, 10);
        wait_idle("lat", 200); tick(1);
        check_motion("lat", 2, 1, 1'b1, 1'b1);

        // Table-driven profiles.
        for (int i = 0; i < 6; i++) begin
            wlist.delete(); dlist.delete(); exp_per.delete();
            for (int j = 0; j < tbl[i].nw; j++) begin wlist.push_back(tbl[i].w[j]); dlist.push_back(0); end
            for (int j = 0; j < tbl[i].n; j++) exp_per.push_back(tbl[i].per[j]);
            run_motion($sformatf("vec%0d", i), tbl[i].uni, tbl[i].n, tbl[i].a, tbl[i].d, tbl[i].dir);
            check_motion($sformatf("vec%0d", i), tbl[i].n, tbl[i].f, tbl[i].dir, 1'b1);
        end

        // Underrun: second word arrives late, motion stalls then resumes.
        wlist = '{10, 10}; dlist = '{0, 15}; exp_per = '{10, 10, 10, 10};
        set_motion(1'b0, 4, 2, 4, 1'b1);
        start = 1'b1; tick(1); start = 1'b0;
        wait_steps("urun", 1, 100);
        tick(2);
        check("urun stall pul_out", pul_out, 0);
        check("urun stall busy", busy, 1);
        check("urun flag", underrun, 1);
        wait_idle("urun", 300); tick(1);
        check("urun sticky", underrun, 1);
        check("urun stretched low", (lo_q.size() > 0 && lo_q[0] > 5) ? 1 : 0, 1);
        check_motion("urun", 4, 2, 1'b1, 1'b0);
        wlist = '{4}; dlist = '{0}; exp_per = '{4};
        set_motion(1'b1, 1, 0, 0, 1'b1);
        start = 1'b1; tick(1); start = 1'b0;
        check("urun cleared on start", underrun, 0);
        wait_idle("urun2", 100); tick(1);
        check_motion("urun2", 1, 1, 1'b1, 1'b1);

        // Hold after step 1, ignored start while busy, then abort in step 3.
        wlist = '{10}; dlist = '{0};
        set_motion(1'b1, 6, 0, 0, 1'b0);
        start = 1'b1; tick(1); start = 1'b0;
        wait_steps("hold", 1, 100);
        hold = 1'b1;
        wait_steps("hold", 2, 100);
        tick(5);
        check("hold pul_out", pul_out, 0);
        check("hold busy", busy, 1);
        check("hold step_cnt", step_cnt, 2);
        step = 32'd2; start = 1'b1; tick(1); start = 1'b0;
        check("busy start per_ready", per_ready, 0);
        check("busy start busy", busy, 1);
        hold = 1'b0;
        wait_steps("hold", 3, 100);
        tick(3);
        check("mid step pul_out", pul_out, 1);
        abort = 1'b1; tick(1); abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort pul_out", pul_out, 0);
        check("abort step_cnt", step_cnt, 3);
        tick(2);
        check("abort done_pulses", done_cnt, 0);
        exp_pos = exp_pos - 8'sd3;
        check("abort step_pos", longint'(step_pos), longint'(exp_pos));

        // Position wrap and clear.
        pos_clr = 1'b1; tick(1); pos_clr = 1'b0;
        exp_pos = '0;
        check("pos_clr idle", longint'(step_pos), 0);
        wlist = '{2}; dlist = '{0}; exp_per.delete();
        for (int k = 0; k < 127; k++) exp_per.push_back(2);
        run_motion("pos127", 1'b1, 127, 0, 0, 1'b1);
        check_motion("pos127", 127, 1, 1'b1, 1'b1);
        exp_per = '{2};
        run_motion("poswrap", 1'b1, 1, 0, 0, 1'b1);
        check_motion("poswrap", 1, 1, 1'b1, 1'b1);
        check("pos wrap value", longint'(step_pos), -128);
        wlist = '{4};
        set_motion(1'b1, 1, 0, 0, 1'b1);
        start = 1'b1; tick(1); start = 1'b0;
        wait_pulse("posclr", 50);
        tick(3);
        pos_clr = 1'b1; tick(1); pos_clr = 1'b0;
        check("pos_clr vs step", longint'(step_pos), 0);
        check("pos_clr done", done, 1);
        exp_pos = '0;
        tick(2);

        // Random profiles against the reference model.
        for (int r = 0; r < 30; r++) begin
            bit uni, dir;
            int n, a, d;
            uni = 1'($urandom_range(0, 1));
            dir = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 10);
            a = $urandom_range(0, 12);
            d = $urandom_range(0, 12);
            build_random(uni, n, a, d);
            run_motion($sformatf("rnd%0d", r), uni, n, a, d, dir);
            check_motion($sformatf("rnd%0d", r), n, wlist.size(), dir, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/motor_profile_ctrl.md
# motor_profile_ctrl

Single-axis step/direction pulse engine, successor to the DDR-fed motor controller. Step-period words arrive from the PS-side DDR reader over a valid/ready stream into a one-entry prefetch buffer. The block runs accelerate/cruise/decelerate or uniform profiles with widths set by parameters. It adds hold/resume, abort, underrun detection, a completion pulse and a wrapping signed position counter.

## Interface
- `STEP_W`, 32: width of step counts.
- `PER_W`, 32: width of period words, in clk cycles.
- `PHASE_W`, 16: width of `accel_end` and `decel_begin`.
- `POS_W`, 32: width of the signed position counter.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle start request; sampled only in IDLE.
- `abort` in 1: terminate motion immediately.
- `hold` in 1: pause at the next step boundary while high.
- `pul_mode` in 2: 01 selects accel/decel, 10 selects uniform; other values make `start` ignored.
- `step` in STEP_W: total steps N.
- `accel_end` in PHASE_W: first step index that reuses the period.
- `decel_begin` in PHASE_W: first step index of deceleration.
- `pul_dir` in 1: direction, 1 = positive.
- `pos_clr` in 1: clear the position counter.
- `per_data` in PER_W: period word.
- `per_valid` in 1: period word valid.
- `per_ready` out 1: block accepts a period word.
- `pul_out` out 1: step pulse.
- `dir_out` out 1: latched direction.
- `busy` out 1: motion in progress.
- `done` out 1: one-cycle pulse on completion.
- `underrun` out 1: sticky flag, period data arrived late.
- `step_cnt` out STEP_W: completed steps.
- `step_pos` out POS_W: signed position.
- `cur_period` out PER_W: active period.

## Operation
- States: IDLE, PRIME, RUN, HOLD, STALL.
- IDLE → PRIME on `start` when `step`≠0 and `pul_mode` ∈ {01,10}. Otherwise `start` is ignored.
- At that transition the block latches N, mode, `pul_dir`, a_eff = max(`accel_end`,1) and d = `decel_begin`. It also clears `step_cnt`, the fetch counter and `underrun`.
- `start` while busy is ignored.
- Step k ∈ [0,N) needs a fresh period when:
  - uniform mode: k==0 only;
  - accel mode: k < a_eff or k ≥ d.
- Fetches needed F:
  - uniform: 1;
  - accel with a_eff ≥ d: N;
  - accel otherwise: min(a_eff,N) + N − min(d,N).
- `per_ready` = busy && !buf_vld && (fetch_cnt < F). Each handshake fills the buffer and increments fetch_cnt.
- Each period word is clamped to a minimum of 2. Within a period P, `pul_out` is high while period_cnt < P>>1 and low otherwise.
- PRIME: wait for buf_vld, then consume it into `cur_period` and go to RUN with period_cnt=0.
- RUN, at period_cnt==P−1:
  - increment `step_cnt` and update `step_pos`;
  - if `step_cnt`+1==N: pulse `done` and go to IDLE;
  - else if `hold`: go to HOLD;
  - else if the next step needs a fresh period: consume buf_vld, or go to STALL and set `underrun` if the buffer is empty;
  - else reuse `cur_period`.
- HOLD: `pul_out` low. When `hold` drops, apply the same next-step decision as the RUN boundary.
- STALL: `pul_out` low. Consume the buffer when buf_vld and go to RUN.
- `abort` in any busy state: go to IDLE next cycle, empty the buffer, drive `pul_out` low, no `done`. `step_cnt` and `step_pos` are kept.
- `step_pos`: +1 when the latched dir is 1, −1 otherwise, modulo 2^POS_W. `pos_clr` wins over a same-cycle update, giving 0. `pos_clr` works in any state.

## Timing
- Reset values:
  - state IDLE;
  - `per_ready`, `pul_out`, `busy`, `done`, `underrun`, `dir_out` all 0;
  - `step_cnt`, `step_pos`, `cur_period` all 0;
  - buffer empty.
- `rst` overrides `abort` and `start`.
- All outputs are registered or decoded from registers only. There is no combinational input→output path except through `per_ready`'s registered terms.
- Handshake:
  - a transfer occurs on a cycle where both `per_valid` and `per_ready` are 1;
  - `per_data` must be held while `per_valid` is high and `per_ready` is low;
  - buf_vld is set the cycle after the transfer.
- Start latency: `start` at cycle t, then PRIME at t+1. A handshake at t+1 gives buf_vld at t+2, RUN at t+3, and the first `pul_out` high at t+3.
- A step boundary followed by a buffered fetch gives back-to-back periods with no gap cycle.
- `done` is asserted the cycle after the last period's final cycle, together with `busy` falling.

## Test plan
- Uniform mode, N=3, one word 10 → exactly 1 fetch; 3 pulses each 5 high / 5 low; `step_pos`=+3; one `done` pulse.
- Accel mode, N=6, `accel_end`=2, `decel_begin`=4, words 20,10,10,20 → 4 fetches; periods 20,10,10,10,10,20; `per_ready` stays 0 after the 4th fetch.
- Underrun: the 2nd word is delayed 15 cycles → STALL with `pul_out` low for those cycles; `underrun`=1 and stays set; motion resumes; `underrun` clears on the next `start`.
- Hold then abort: raise `hold` in step 1 → HOLD after step 1 completes; release → resumes. `abort` mid-step 3 → IDLE next cycle, no `done`, `step_cnt`=3.
- Position: POS_W=8, `step_pos`=127, dir=1, one step → −128; `pos_clr` on the step-completion cycle → 0.
- Ignored starts: `step`=0, `pul_mode`=11, or `start` while busy → no state change and `per_ready` stays as before.
